// File: rtl/serial_accumulator_with_rounding_pkg.sv
// Shared number helpers for the serial and parallel multi-input adders:
// accumulator sizing, round-half-to-even with saturation, and the accumulator FSM states.
package serial_accumulator_with_rounding_pkg;

    typedef enum logic [1:0] {
        ACC = 2'd0,
        RND = 2'd1,
        OUT = 2'd2
    } acc_state_t;

    localparam int MAX_WIDTH = 64;
    localparam logic signed [MAX_WIDTH-1:0] ONE = 1;

    typedef struct packed {
        logic [MAX_WIDTH-1:0] value;
        logic                 sat;
    } rnd_result_t;

    function automatic int acc_width(input int num_input, input int width_in);
        return width_in + $clog2(num_input);
    endfunction

    // value must already be sign- or zero-extended to MAX_WIDTH; d=0 skips rounding and only clamps
    function automatic rnd_result_t round_half_even_sat(
        input logic signed [MAX_WIDTH-1:0] value,
        input int                          d,
        input int                          width_out,
        input logic                        is_signed
    );
        logic signed [MAX_WIDTH-1:0] q;
        logic signed [MAX_WIDTH-1:0] rem;
        logic signed [MAX_WIDTH-1:0] half;
        logic signed [MAX_WIDTH-1:0] max_v;
        logic signed [MAX_WIDTH-1:0] min_v;
        rnd_result_t                 res;
        q    = value;
        rem  = '0;
        half = '0;
        if (d > 0) begin
            q    = value >>> d;
            rem  = value - (q <<< d);
            half = ONE <<< (d - 1);
            if ((rem > half) || ((rem == half) && q[0])) begin
                q = q + ONE;
            end
        end
        if (is_signed) begin
            max_v = (ONE <<< (width_out - 1)) - ONE;
            min_v = -(ONE <<< (width_out - 1));
        end else begin
            max_v = (ONE <<< width_out) - ONE;
            min_v = '0;
        end
        res.value = q;
        res.sat   = 1'b0;
        if (q > max_v) begin
            res.value = max_v;
            res.sat   = 1'b1;
        end else if (q < min_v) begin
            res.value = min_v;
            res.sat   = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/serial_accumulator_with_rounding_if.sv
// Term input stream and rounded-result output stream of the serial accumulator.
interface serial_accumulator_with_rounding_if #(
    parameter int WIDTH_IN  = 8,
    parameter int WIDTH_OUT = 8
);
    logic [WIDTH_IN-1:0]  in_data;
    logic                 in_valid;
    logic                 in_last;
    logic                 in_ready;
    logic [WIDTH_OUT-1:0] out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_sat;
    logic                 out_err;

    modport master (
        output in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_valid, out_sat, out_err
    );

    modport slave (
        input  in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_valid, out_sat, out_err
    );
endinterface

// File: rtl/serial_accumulator_with_rounding_round_sat_stage.sv
// Registered width reduction of the frame sum: round-half-to-even in fractional mode,
// plain clamping in integer mode, captured once per frame while the FSM sits in RND.
module serial_accumulator_with_rounding_round_sat_stage #(
    parameter int WIDTH_ACC   = 10,
    parameter int WIDTH_OUT   = 8,
    parameter int IS_SIGNED   = 1,
    parameter int IS_FRACTION = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [WIDTH_ACC-1:0] acc,
    input  logic                 err_in,
    output logic [WIDTH_OUT-1:0] out_data,
    output logic                 out_sat,
    output logic                 out_err
);
    import serial_accumulator_with_rounding_pkg::*;

    localparam int D = (IS_FRACTION != 0) ? (WIDTH_ACC - WIDTH_OUT) : 0;

    logic signed [MAX_WIDTH-1:0] acc_ext;
    rnd_result_t                 rnd;
    logic                        unused_hi;

    always_comb begin
        if (IS_SIGNED != 0) begin
            acc_ext = {{(MAX_WIDTH-WIDTH_ACC){acc[WIDTH_ACC-1]}}, acc};
        end else begin
            acc_ext = {{(MAX_WIDTH-WIDTH_ACC){1'b0}}, acc};
        end
        rnd = round_half_even_sat(acc_ext, D, WIDTH_OUT, IS_SIGNED != 0);
    end

    // Clamping guarantees the result fits WIDTH_OUT, so the upper bits carry no information.
    assign unused_hi = ^rnd.value[MAX_WIDTH-1:WIDTH_OUT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_sat  <= 1'b0;
            out_err  <= 1'b0;
        end else if (load) begin
            out_data <= rnd.value[WIDTH_OUT-1:0];
            out_sat  <= rnd.sat;
            out_err  <= err_in;
        end
    end

endmodule

// File: rtl/serial_accumulator_with_rounding.sv
// Serial frame accumulator: sums NUM_INPUT streamed terms, then hands the full-width sum to the
// rounding stage and presents one rounded, saturated result per frame on a valid/ready port.
module serial_accumulator_with_rounding #(
    parameter int NUM_INPUT   = 4,
    parameter int WIDTH_IN    = 8,
    parameter int WIDTH_OUT   = 8,
    parameter int IS_SIGNED   = 1,
    parameter int IS_FRACTION = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clr,
    serial_accumulator_with_rounding_if.slave bus
);
    import serial_accumulator_with_rounding_pkg::*;

    localparam int WIDTH_ACC = acc_width(NUM_INPUT, WIDTH_IN);
    localparam int CNT_W     = $clog2(NUM_INPUT) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_INPUT - 1);

    acc_state_t           state;
    acc_state_t           state_next;
    logic [WIDTH_ACC-1:0] acc;
    logic [WIDTH_ACC-1:0] term_ext;
    logic [CNT_W-1:0]     cnt;
    logic                 err;
    logic                 beat;
    logic                 at_last;
    logic                 frame_end;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 rnd_load;

    assign beat      = bus.in_valid && in_ready_q;
    assign at_last   = (cnt == LAST_CNT);
    assign frame_end = beat && (at_last || bus.in_last);
    assign term_ext  = {{(WIDTH_ACC-WIDTH_IN){(IS_SIGNED != 0) && bus.in_data[WIDTH_IN-1]}}, bus.in_data};
    assign rnd_load  = (state == RND) && !clr;

    always_comb begin
        state_next = state;
        case (state)
            ACC:     if (frame_end) state_next = RND;
            RND:     state_next = OUT;
            OUT:     if (bus.out_ready) state_next = ACC;
            default: state_next = ACC;
        endcase
        if (clr) begin
            state_next = ACC;
        end
    end

    // in_ready/out_valid are registered from the next state so they stay low throughout reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACC;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            in_ready_q  <= (state_next == ACC);
            out_valid_q <= (state_next == OUT);
        end
    end

    // A zero count marks the first beat, which loads rather than adds so no clearing cycle is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            err <= 1'b0;
        end else if (beat) begin
            acc <= (cnt == '0) ? term_ext : (acc + term_ext);
            cnt <= cnt + 1'b1;
            err <= err | (bus.in_last != at_last);
        end else if ((state == OUT) && bus.out_ready) begin
            cnt <= '0;
            err <= 1'b0;
        end
    end

    serial_accumulator_with_rounding_round_sat_stage #(
        .WIDTH_ACC   (WIDTH_ACC),
        .WIDTH_OUT   (WIDTH_OUT),
        .IS_SIGNED   (IS_SIGNED),
        .IS_FRACTION (IS_FRACTION)
    ) u_round_sat_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (rnd_load),
        .acc      (acc),
        .err_in   (err),
        .out_data (bus.out_data),
        .out_sat  (bus.out_sat),
        .out_err  (bus.out_err)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;

endmodule
